// File: rtl/speech256_allo_rx.sv
// Speech256 allophone load responder: strobe edge detect, code FIFO, ldq handshake.
// Optional ALLO_FLUSH_EN macro adds a synchronous flush input.
module speech256_allo_rx #(
  parameter int DEPTH_LOG2 = 2,
  parameter int DATA_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_stb,
  output logic              ldq,
  output logic [DATA_W-1:0] alloph_out,
  output logic              alloph_valid,
  input  logic              alloph_ack,
  output logic              busy,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef ALLO_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0]     head, tail;
  logic [PW-1:0]     head_nx, tail_nx;
  logic [CW-1:0]     count, count_nx;
  logic              stb_d;
  logic              ldq_r, ovf_r;
  logic [DATA_W-1:0] out_r, out_nx;

  logic push_req, full, pop;
  logic push_ok, drop;
  logic ldq_hold, ldq_nx;
  logic do_flush;

`ifdef ALLO_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  always_comb begin
    push_req = data_stb & ~stb_d;
    full     = (count == DEPTH_C);
    pop      = (count != '0) & alloph_ack;
    push_ok  = push_req & ~full & ~do_flush;
    drop     = push_req & full & ~do_flush;
    ldq_hold = push_ok | do_flush;

    head_nx  = head;
    tail_nx  = tail;
    count_nx = count + CW'(push_ok) - CW'(pop);
    if (pop) head_nx = head + ONE_P;
    if (push_ok) tail_nx = tail + ONE_P;
    if (do_flush) begin
      head_nx  = '0;
      tail_nx  = '0;
      count_nx = '0;
    end

    ldq_nx = ~ldq_hold & (count_nx < DEPTH_C);

    // Next head may be the code being written this very edge.
    if (do_flush)
      out_nx = '0;
    else if (push_ok && (tail == head_nx))
      out_nx = data_in;
    else
      out_nx = mem[head_nx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      stb_d <= 1'b0;
      ldq_r <= 1'b0;
      ovf_r <= 1'b0;
      out_r <= '0;
    end else begin
      head  <= head_nx;
      tail  <= tail_nx;
      count <= count_nx;
      stb_d <= data_stb;
      ldq_r <= ldq_nx;
      out_r <= out_nx;
      if (drop)
        ovf_r <= 1'b1;
      else if (clr_ovf)
        ovf_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[tail] <= data_in;
  end

  assign ldq          = ldq_r;
  assign overflow     = ovf_r;
  assign alloph_out   = out_r;
  assign alloph_valid = (count != '0);
  assign busy         = alloph_valid;

endmodule

// File: tb/tb_speech256_allo_rx.sv
// Bench for speech256_allo_rx: queue-based reference model plus scoreboard monitor.
// Directed load-protocol cases followed by randomized traffic.
module tb_speech256_allo_rx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] data_in;
  logic       data_stb;
  logic       ldq;
  logic [5:0] alloph_out;
  logic       alloph_valid;
  logic       alloph_ack;
  logic       busy;
  logic       overflow;
  logic       clr_ovf;
  logic       flush;

  speech256_allo_rx #(.DEPTH_LOG2(2), .DATA_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_stb     (data_stb),
    .ldq          (ldq),
    .alloph_out   (alloph_out),
    .alloph_valid (alloph_valid),
    .alloph_ack   (alloph_ack),
    .busy         (busy),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
`ifdef ALLO_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: occupancy as a plain queue, updated per clock.
  logic [5:0] mq[$];
  logic [5:0] exp_q[$];
  bit         prev_stb;
  bit         ldq_exp;
  bit         ovf_exp;
  bit         rise, acc, popm;
  int         sz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      prev_stb = 0;
      ldq_exp  = 0;
      ovf_exp  = 0;
    end else begin
      sz       = mq.size();
      rise     = data_stb && !prev_stb;
      prev_stb = data_stb;
      acc      = 0;
      popm     = (sz > 0) && alloph_ack;
      if (flush) begin
        mq.delete();
        exp_q.delete();
        ldq_exp = 0;
        if (clr_ovf) ovf_exp = 0;
      end else begin
        if (rise && sz < DEPTH) acc = 1;
        if (rise && sz >= DEPTH) ovf_exp = 1;
        else if (clr_ovf) ovf_exp = 0;
        if (popm) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(data_in);
          exp_q.push_back(data_in);
        end
        ldq_exp = !acc && (mq.size() < DEPTH);
      end
    end
  end

  // Monitor: per-cycle status checks and in-order consumption scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ldq", {7'b0, ldq}, 8'd0);
      chk("rst_valid", {7'b0, alloph_valid}, 8'd0);
      chk("rst_ovf", {7'b0, overflow}, 8'd0);
      chk("rst_out", {2'b0, alloph_out}, 8'd0);
    end else begin
      chk("ldq", {7'b0, ldq}, {7'b0, ldq_exp});
      chk("valid", {7'b0, alloph_valid}, {7'b0, mq.size() != 0});
      chk("busy", {7'b0, busy}, {7'b0, mq.size() != 0});
      chk("overflow", {7'b0, overflow}, {7'b0, ovf_exp});
      if (mq.size() != 0)
        chk("head", {2'b0, alloph_out}, {2'b0, mq[0]});
      if (alloph_valid && alloph_ack) begin
        if (exp_q.size() == 0)
          chk("order_empty", {7'b0, alloph_valid}, 8'd0);
        else
          chk("order", {2'b0, alloph_out}, {2'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [5:0] code, input int hold);
    data_in  = code;
    data_stb = 1'b1;
    repeat (hold) step();
    data_stb = 1'b0;
    step();
  endtask

  task automatic drain();
    alloph_ack = 1'b1;
    repeat (DEPTH + 1) step();
    alloph_ack = 1'b0;
    step();
  endtask

  logic [5:0] fill_codes [5] = '{6'h1B, 6'h07, 6'h2D, 6'h35, 6'h03};

  initial begin
    rst        = 1'b1;
    data_in    = '0;
    data_stb   = 1'b0;
    alloph_ack = 1'b0;
    clr_ovf    = 1'b0;
    flush      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    strobe(6'h1B, 1);
    step();
    drain();

    strobe(6'h07, 5);
    step();
    drain();

    for (int i = 0; i < 5; i++) strobe(fill_codes[i], 1);
    step();
    repeat (4) begin
      alloph_ack = 1'b1;
      step();
    end
    alloph_ack = 1'b0;
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    step();

    strobe(6'h11, 1);
    strobe(6'h12, 1);
    for (int i = 0; i < 10; i++) begin
      data_in    = 6'(8'h20 + i);
      data_stb   = 1'b1;
      alloph_ack = 1'b1;
      step();
      data_stb   = 1'b0;
      alloph_ack = 1'b0;
      step();
    end
    drain();

`ifdef ALLO_FLUSH_EN
    strobe(6'h01, 1);
    strobe(6'h02, 1);
    strobe(6'h04, 1);
    data_in  = 6'h3F;
    data_stb = 1'b1;
    flush    = 1'b1;
    step();
    data_stb = 1'b0;
    flush    = 1'b0;
    repeat (3) step();
`endif

    for (int i = 0; i < 3000; i++) begin
      data_in    = 6'($urandom);
      data_stb   = ($urandom_range(0, 2) == 0);
      alloph_ack = ($urandom_range(0, 3) == 0);
      clr_ovf    = ($urandom_range(0, 15) == 0);
`ifdef ALLO_FLUSH_EN
      flush      = ($urandom_range(0, 63) == 0);
`endif
      step();
    end
    data_stb   = 1'b0;
    clr_ovf    = 1'b0;
    flush      = 1'b0;
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/speech256_allo_rx.md
Name: speech256_allo_rx

Overview:
- Responder end of the Speech256 allophone load interface: accepts 6-bit allophone codes on data_in/data_stb and signals readiness on ldq.
- Buffers codes in a small FIFO and hands them to the internal sequencer over a valid/ack handshake.
- Sits between the board/host command logic and the allophone sequencer inside the Speech256 core.
- Preserves the load protocol: the host strobes a code, waits for ldq low, then waits for ldq high before the next code.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries); legal range 1..4.
- DATA_W, 6, allophone code width.

Ports:
- clk  input  1  system clock (2.5 MHz on DE0).
- rst  input  1  asynchronous reset, active-high.
- data_in  input  DATA_W  allophone code from host.
- data_stb  input  1  load strobe; may be held high for several cycles.
- ldq  output  1  load request/ready (1 = a code can be accepted).
- alloph_out  output  DATA_W  FIFO head code.
- alloph_valid  output  1  head is valid (FIFO not empty).
- alloph_ack  input  1  sequencer consumes head.
- busy  output  1  FIFO holds at least one code.
- overflow  output  1  sticky: a strobe arrived while full.
- clr_ovf  input  1  synchronous clear of overflow.
- flush  input  1  present only when ALLO_FLUSH_EN is defined.

Behaviour:
- Reset (async, rst=1): pointers=0, count=0, stb_d=0, ldq=0, ldq_hold=0, overflow=0, alloph_valid=0, busy=0, alloph_out=0.
- After reset deasserts, ldq=1 from the first clk edge.
- Strobe detect: stb_d registers data_stb; push_req = data_stb & ~stb_d (rising edge). A strobe held N cycles produces exactly one push.
- Push accepted when push_req & (count < DEPTH). data_in is written at the tail; tail and count increment on the same edge.
- Push request while count == DEPTH: code dropped, overflow <= 1, pointers unchanged.
- A full FIFO rejects a push even if a pop occurs in the same cycle.
- ldq is registered:
  - ldq <= 0 on the edge after any accepted push (ldq_hold), for exactly 1 cycle.
  - Otherwise ldq <= (count_next < DEPTH).
  - This guarantees the host sees ldq drop after every accepted code.
- Pop: when alloph_valid & alloph_ack, head and count decrement. alloph_ack while empty is ignored.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Output side:
  - alloph_valid = (count != 0) and busy = alloph_valid, both combinational from registered count.
  - alloph_out = mem[head], registered read, so it is valid in the same cycle alloph_valid rises.
  - Latency from accepted push (edge k) to alloph_valid=1 on an empty FIFO is 1 cycle (visible after edge k).
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. count is DEPTH_LOG2+1 bits.
- overflow: set on a dropped push, cleared by clr_ovf. If both occur in the same cycle, set wins.
- No internal state machine beyond the strobe edge detector and ldq_hold. Code values are not interpreted; all 64 codes are passed through.

Optional Feature:
- Macro: ALLO_FLUSH_EN.
- With the macro defined: flush port exists. flush=1 synchronously sets head=tail=count=0 and ldq <= 0 for 1 cycle, then ldq=1. Any push_req in the same cycle is dropped and does not set overflow. overflow is unaffected. stb_d keeps tracking data_stb.
- Without the macro: no flush port; FIFO empties only via pops or rst.

Test Plan:
- Reset then idle: rst pulse, no stimulus -> ldq=1, alloph_valid=0, overflow=0 from the first edge after release.
- Single load: data_in=6'h1B, data_stb high 1 cycle, alloph_ack=0 -> ldq low exactly 1 cycle then high; alloph_valid=1 with alloph_out=6'h1B the cycle after the strobe.
- Held strobe: data_in=6'h07, data_stb high 5 cycles -> exactly one entry written (count=1).
- Fill/overflow (DEPTH=4): push 1B,07,2D,35 with no acks, then a fifth strobe 03 -> ldq=0 after the 4th push and stays 0; overflow=1. Ack 4 times -> outputs 1B,07,2D,35 in order, 03 never appears. clr_ovf -> overflow=0.
- Simultaneous push/pop with wrap: keep count=2 while pushing 10 codes with ack every cycle -> all 10 emerge in order, count stays 2, pointers wrap without loss.
- ALLO_FLUSH_EN: push 3 codes, assert flush together with a new strobe -> count=0, alloph_valid=0, ldq low 1 cycle then high, overflow=0.
